// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the control unit and the HI/LO multiply-divide unit.
// Latency: none, this file only groups wires.
// Backpressure: the control unit stalls on busy and holds off further requests.
interface muldiv_unit_if;
  logic        start;
  logic [5:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  modport master (
    output start, alucontrol, srca, srcb,
    input  busy, done, hi, lo, result
  );

  modport slave (
    input  start, alucontrol, srca, srcb,
    output busy, done, hi, lo, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 restoring divide unit owning the MIPS HI/LO registers.
// Latency: 32 RUN cycles plus 1 FIX cycle; done pulses the cycle after FIX. mthi/mtlo take one edge.
// Backpressure: busy is high through RUN and FIX, and start is ignored while busy.
module muldiv_unit (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [63:0] acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;     // sign of product / quotient
  logic        rneg_q, rneg_d;   // sign of remainder (follows dividend)
  logic        dz_q, dz_d;       // divide by zero: quotient forced to all ones
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // One step of each datapath, computed from the current accumulator.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod_neg;
  logic [31:0] quo_neg;
  logic [31:0] rem_neg;

  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign mul_next  = {mul_sum, acc_q[31:1]};
  assign div_trial = {acc_q[63:32], acc_q[31]};
  assign div_ge    = div_trial >= {1'b0, opnd_q};
  assign div_diff  = div_trial[31:0] - opnd_q;
  assign div_next  = div_ge ? {div_diff, acc_q[30:0], 1'b1}
                            : {div_trial[31:0], acc_q[30:0], 1'b0};
  assign prod_neg  = ~acc_q + 64'd1;
  assign quo_neg   = ~acc_q[31:0] + 32'd1;
  assign rem_neg   = ~acc_q[63:32] + 32'd1;

  // Operand magnitudes and sign bookkeeping for a request arriving in IDLE.
  logic        req_signed;
  logic        req_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign req_signed = ~bus.alucontrol[0];
  assign req_div    = bus.alucontrol[1];
  assign a_mag      = (req_signed && bus.srca[31]) ? (~bus.srca + 32'd1) : bus.srca;
  assign b_mag      = (req_signed && bus.srcb[31]) ? (~bus.srcb + 32'd1) : bus.srcb;

  // State register and all datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: accept requests in IDLE, iterate in RUN, sign-fix and write back in FIX.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.alucontrol)
            F_MTHI: hi_d = bus.srca;
            F_MTLO: lo_d = bus.srca;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d  = RUN;
              cnt_d    = 5'd31;
              is_div_d = req_div;
              acc_d    = {32'd0, (req_div ? a_mag : b_mag)};
              opnd_d   = req_div ? b_mag : a_mag;
              neg_d    = req_signed && (bus.srca[31] ^ bus.srcb[31]);
              rneg_d   = req_signed && bus.srca[31];
              dz_d     = req_div && (bus.srcb == 32'd0);
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == 5'd0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rneg_q ? rem_neg : acc_q[63:32];
          lo_d = dz_q ? 32'hFFFF_FFFF : (neg_q ? quo_neg : acc_q[31:0]);
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
  assign bus.result = (bus.alucontrol == F_MFHI) ? hi_q :
                      (bus.alucontrol == F_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: timing, arithmetic corner cases, HI/LO moves, aborts.
// Each scenario task drives its stimulus and compares against hand-computed values.
// Inputs change #1 after the rising edge; outputs are sampled at the same point.
module tb_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the operands so late changes would show up.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start      = 1'b1;
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    tick();
    bus.start      = 1'b0;
    bus.alucontrol = F_ADD;
    bus.srca       = $urandom;
    bus.srcb       = $urandom;
  endtask

  // Full operation: busy through cycles 1-33, done plus new HI/LO exactly at cycle 34.
  task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bad;
    bad = 0;
    issue(op, a, b);
    for (int c = 1; c <= 33; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s busy/done window: %0d bad cycles, required 0", name, bad);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s cycle34: done=%b busy=%b, required done=1 busy=0", name, bus.done, bus.busy);
    end
    checks++;
    if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
      failures++;
      $display("FAIL %s: hi=%h lo=%h, required hi=%h lo=%h", name, bus.hi, bus.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.alucontrol = F_MFHI;
    bus.srca       = 32'd0;
    bus.srcb       = 32'd0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 ||
        bus.result !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h result=%h, required all zero",
               bus.busy, bus.done, bus.hi, bus.lo, bus.result);
    end
    reset = 1'b0;
  endtask

  task automatic test_arith();
    // First start lands in the cycle right after reset deasserts.
    run_op("mult_m1x2", F_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    tick();
    run_op("multu_m1x2", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("divu_7_2", F_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_m7_0", F_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("mult_min_min", F_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run_op("multu_max_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x5", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_m100_m7", F_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14);
  endtask

  task automatic test_moves();
    int bad;
    bad = 0;
    bus.start      = 1'b1;
    bus.alucontrol = F_MTHI;
    bus.srca       = 32'h1234_5678;
    tick();
    bus.start      = 1'b0;
    bus.alucontrol = F_MFHI;
    #1;
    checks++;
    if (bus.result !== 32'h1234_5678 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mthi: result=%h busy=%b done=%b, required 12345678 0 0",
               bus.result, bus.busy, bus.done);
    end
    bus.start      = 1'b1;
    bus.alucontrol = F_MTLO;
    bus.srca       = 32'hA5A5_A5A5;
    tick();
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    bus.start      = 1'b0;
    bus.alucontrol = F_MFLO;
    tick();
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
    checks++;
    if (bus.lo !== 32'hA5A5_A5A5 || bus.result !== 32'hA5A5_A5A5 || bus.hi !== 32'h1234_5678) begin
      failures++;
      $display("FAIL mtlo: lo=%h result=%h hi=%h, required a5a5a5a5 a5a5a5a5 12345678",
               bus.lo, bus.result, bus.hi);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mtlo_busy: %0d cycles with busy/done set, required 0", bad);
    end
    bus.alucontrol = F_ADD;
    #1;
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("FAIL result_other: result=%h, required 0", bus.result);
    end
  endtask

  task automatic test_ignored_op();
    bus.start      = 1'b1;
    bus.alucontrol = F_ADD;
    bus.srca       = 32'hDEAD_BEEF;
    bus.srcb       = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h1234_5678 ||
        bus.lo !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL ignored_op: busy=%b done=%b hi=%h lo=%h, required 0 0 12345678 a5a5a5a5",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_start_during_run();
    int bad;
    bad = 0;
    issue(F_MULT, 32'd3, 32'd5);
    for (int c = 1; c <= 33; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      if (c == 5) begin
        bus.start = 1'b1; bus.alucontrol = F_DIVU; bus.srca = 32'd9; bus.srcb = 32'd3;
      end else if (c == 6) begin
        bus.start = 1'b1; bus.alucontrol = F_MTHI; bus.srca = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0; bus.alucontrol = F_MFLO;
      end
      if (c == 10) begin
        #1;
        checks++;
        if (bus.result !== 32'hA5A5_A5A5 || bus.hi !== 32'h1234_5678) begin
          failures++;
          $display("FAIL stale_while_busy: result=%h hi=%h, required a5a5a5a5 12345678",
                   bus.result, bus.hi);
        end
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ignore_run busy/done window: %0d bad cycles, required 0", bad);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd15) begin
      failures++;
      $display("FAIL ignore_run result: done=%b hi=%h lo=%h, required 1 0 f",
               bus.done, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    bad = 0;
    issue(F_MULT, 32'd3, 32'd5);
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required all zero",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    for (int c = 0; c < 40; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== 32'd0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: %0d cycles with activity, required 0", bad);
    end
    run_op("mult_after_reset", F_MULT, 32'd6, 32'd7, 32'd0, 32'd42);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", F_MULT, 32'd4, 32'd5, 32'd0, 32'd20);
    // Issued while done is high: must be accepted immediately.
    run_op("b2b_div", F_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_settle: done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_arith();
    test_moves();
    test_ignored_op();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
